// File: rtl/mips_pkg.sv
// MIPS mnemonic codes, opcode/func constants and field packers.
// Shared by the instruction encoder and the control path.
package mips_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLT   = 5'd5,
    OP_SLTU  = 5'd6,
    OP_JR    = 5'd7,
    OP_ADDI  = 5'd8,
    OP_ANDI  = 5'd9,
    OP_ORI   = 5'd10,
    OP_XORI  = 5'd11,
    OP_SLTI  = 5'd12,
    OP_SLTIU = 5'd13,
    OP_LUI   = 5'd14,
    OP_BEQ   = 5'd15,
    OP_BNE   = 5'd16,
    OP_LW    = 5'd17,
    OP_SW    = 5'd18,
    OP_J     = 5'd19,
    OP_JAL   = 5'd20
  } mnem_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FULL,
    S_ERR
  } enc_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic [31:0] pack_r(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] pack_i(
    input logic [5:0]  opc,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: mnemonic + fields -> 32-bit word.
// Codes above JAL are reported illegal and yield a zero word.
module instr_pack
  import mips_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_legal
);

  // Select the format and constant for the requested mnemonic
  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (i_op)
      OP_ADD:   o_word = pack_r(i_rs, i_rt, i_rd, FN_ADD);
      OP_SUB:   o_word = pack_r(i_rs, i_rt, i_rd, FN_SUB);
      OP_AND:   o_word = pack_r(i_rs, i_rt, i_rd, FN_AND);
      OP_OR:    o_word = pack_r(i_rs, i_rt, i_rd, FN_OR);
      OP_XOR:   o_word = pack_r(i_rs, i_rt, i_rd, FN_XOR);
      OP_SLT:   o_word = pack_r(i_rs, i_rt, i_rd, FN_SLT);
      OP_SLTU:  o_word = pack_r(i_rs, i_rt, i_rd, FN_SLTU);
      OP_JR:    o_word = pack_r(i_rs, 5'd0, 5'd0, FN_JR);
      OP_ADDI:  o_word = pack_i(OPC_ADDI, i_rs, i_rt, i_imm);
      OP_ANDI:  o_word = pack_i(OPC_ANDI, i_rs, i_rt, i_imm);
      OP_ORI:   o_word = pack_i(OPC_ORI, i_rs, i_rt, i_imm);
      OP_XORI:  o_word = pack_i(OPC_XORI, i_rs, i_rt, i_imm);
      OP_SLTI:  o_word = pack_i(OPC_SLTI, i_rs, i_rt, i_imm);
      OP_SLTIU: o_word = pack_i(OPC_SLTIU, i_rs, i_rt, i_imm);
      OP_LUI:   o_word = pack_i(OPC_LUI, 5'd0, i_rt, i_imm);
      OP_BEQ:   o_word = pack_i(OPC_BEQ, i_rs, i_rt, i_imm);
      OP_BNE:   o_word = pack_i(OPC_BNE, i_rs, i_rt, i_imm);
      OP_LW:    o_word = pack_i(OPC_LW, i_rs, i_rt, i_imm);
      OP_SW:    o_word = pack_i(OPC_SW, i_rs, i_rt, i_imm);
      OP_J:     o_word = {OPC_J, i_target};
      OP_JAL:   o_word = {OPC_JAL, i_target};
      default:  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts encode requests and writes the packed
// words sequentially into instruction memory.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err,
  output logic [4:0]            err_op
);

  enc_state_e            r_state;
  enc_state_e            w_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [31:0]           r_word;
  logic [4:0]            r_err_op;
  logic [31:0]           w_word;
  logic                  w_legal;
  logic                  w_hs;

  instr_pack u_pack (
    .i_op     (in_op),
    .i_rs     (in_rs),
    .i_rt     (in_rt),
    .i_rd     (in_rd),
    .i_imm    (in_imm),
    .i_target (in_target),
    .o_word   (w_word),
    .o_legal  (w_legal)
  );

  assign w_hs       = in_valid & in_ready;
  assign imem_addr  = r_ptr;
  assign imem_wdata = r_word;
  assign count      = r_count;
  assign err_op     = r_err_op;
  assign full       = (r_state == S_FULL);
  assign err        = (r_state == S_ERR);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state, handshake and write strobe; clear wins everywhere
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = !clear;
        if (!clear && in_valid)
          w_next = w_legal ? S_WRITE : S_ERR;
      end
      S_WRITE: begin
        imem_we = !clear;
        if (clear)       w_next = S_IDLE;
        else if (&r_ptr) w_next = S_FULL;
        else             w_next = S_IDLE;
      end
      S_FULL:  if (clear) w_next = S_IDLE;
      S_ERR:   if (clear) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Word latch, write pointer, count and error capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_count  <= '0;
      r_word   <= '0;
      r_err_op <= '0;
    end else if (clear) begin
      r_ptr    <= '0;
      r_count  <= '0;
      r_err_op <= '0;
    end else begin
      if (w_hs && w_legal)  r_word   <= w_word;
      if (w_hs && !w_legal) r_err_op <= in_op;
      if (r_state == S_WRITE) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule
